// File: rtl/slp_train_ctrl_pkg.sv
// slp_train_ctrl_pkg: shared types for the slp training sequencer
package slp_train_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, EVAL, EPOCH_END, DONE} slp_ctrl_state_t;
endpackage

// File: rtl/slp_train_ctrl_buf.sv
// slp_train_ctrl_buf: labelled sample store, one write port, one async read port
module slp_train_ctrl_buf #(
  parameter int DEPTH = 16,
  parameter int W = 72,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/slp_train_ctrl.sv
// slp_train_ctrl: replays a stored sample set into an slp epoch by epoch,
// counting mispredictions and decaying the learning rate until convergence or the epoch limit
module slp_train_ctrl
  import slp_train_ctrl_pkg::*;
#(
  parameter int IN = 8,
  parameter int I_PREC = 8,
  parameter int O_PREC = 8,
  parameter int R_PREC = 8,
  parameter int DEPTH = 16,
  parameter int MAX_EPOCH = 64,
  parameter logic [R_PREC-1:0] RATE_INIT = 8'h40,
  parameter int RATE_SHIFT = 1,
  parameter logic [R_PREC-1:0] RATE_MIN = 8'h01,
  localparam int EW = (MAX_EPOCH > 1) ? $clog2(MAX_EPOCH) : 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH),
  localparam int SW = IN * I_PREC
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [SW-1:0]     ld_in,
  input  logic [O_PREC-1:0] ld_train,
  input  logic              clr,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [EW-1:0]     epoch,
  output logic [CW-1:0]     err_cnt,
  output logic [SW-1:0]     slp_in,
  output logic [O_PREC-1:0] slp_train,
  output logic [R_PREC-1:0] slp_rate,
  output logic              slp_t_en,
  input  logic [O_PREC-1:0] slp_out
);
  slp_ctrl_state_t   state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, err_cnt_q, err_cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [EW-1:0]     epoch_q, epoch_d;
  logic [SW-1:0]     slp_in_q, slp_in_d;
  logic [O_PREC-1:0] slp_train_q, slp_train_d;
  logic [R_PREC-1:0] slp_rate_q, slp_rate_d, rate_sh;
  logic              done_q, done_d, converged_q, converged_d, ld_we;
  logic [SW+O_PREC-1:0] rd_data;
  slp_train_ctrl_buf #(.DEPTH(DEPTH), .W(SW + O_PREC), .AW(AW)) u_buf (
    .clk(clk), .we(ld_we), .waddr(AW'(cnt_q)), .wdata({ld_in, ld_train}),
    .raddr(idx_q), .rdata(rd_data)
  );
  assign ld_ready  = (state_q == IDLE) && (cnt_q < CW'(DEPTH));
  assign busy      = state_q != IDLE;
  assign slp_t_en  = (state_q == EVAL) && !abort;
  assign rate_sh   = slp_rate_q >> RATE_SHIFT;
  assign done      = done_q;
  assign converged = converged_q;
  assign epoch     = epoch_q;
  assign err_cnt   = err_cnt_q;
  assign slp_in    = slp_in_q;
  assign slp_train = slp_train_q;
  assign slp_rate  = slp_rate_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    epoch_d = epoch_q;
    err_cnt_d = err_cnt_q;
    slp_in_d = slp_in_q;
    slp_train_d = slp_train_q;
    slp_rate_d = slp_rate_q;
    converged_d = converged_q;
    ld_we = 1'b0;
    if (abort && state_q inside {FETCH, EVAL, EPOCH_END}) begin
      state_d = IDLE;
      converged_d = 1'b0;
    end else begin
      case (state_q)
        IDLE:
          if (clr) cnt_d = '0;
          else if (start) begin
            converged_d = 1'b0;
            state_d = (cnt_q == '0) ? DONE : FETCH;
            idx_d = '0;
            epoch_d = '0;
            err_cnt_d = '0;
            slp_rate_d = (cnt_q == '0) ? slp_rate_q : RATE_INIT;
          end else if (ld_valid && ld_ready) begin
            ld_we = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
        FETCH: begin
          {slp_in_d, slp_train_d} = rd_data;
          state_d = EVAL;
        end
        EVAL: begin
          err_cnt_d = err_cnt_q + CW'(slp_out != slp_train_q);
          state_d = (CW'(idx_q) + CW'(1) == cnt_q) ? EPOCH_END : FETCH;
          idx_d = (state_d == FETCH) ? idx_q + 1'b1 : idx_q;
        end
        EPOCH_END:
          if (err_cnt_q == '0) begin
            converged_d = 1'b1;
            state_d = DONE;
          end else if (epoch_q == EW'(MAX_EPOCH - 1)) state_d = DONE;
          else begin
            epoch_d = epoch_q + 1'b1;
            idx_d = '0;
            err_cnt_d = '0;
            slp_rate_d = (rate_sh < RATE_MIN) ? RATE_MIN : rate_sh;
            state_d = FETCH;
          end
        default: state_d = IDLE;
      endcase
    end
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      epoch_q <= '0;
      err_cnt_q <= '0;
      slp_in_q <= '0;
      slp_train_q <= '0;
      slp_rate_q <= RATE_INIT;
      done_q <= 1'b0;
      converged_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      epoch_q <= epoch_d;
      err_cnt_q <= err_cnt_d;
      slp_in_q <= slp_in_d;
      slp_train_q <= slp_train_d;
      slp_rate_q <= slp_rate_d;
      done_q <= done_d;
      converged_q <= converged_d;
    end
  end
endmodule

// File: tb/tb_slp_train_ctrl.sv
// tb_slp_train_ctrl: randomized replay checks against a per-epoch error-table model
module tb_slp_train_ctrl;
  localparam int IN = 2, IP = 8, OP = 8, DEPTH = 16, MAXE = 8, SW = IN * IP;
  logic clk = 0, reset_ = 0, ld_valid = 0, clr = 0, start = 0, abort = 0;
  logic ld_ready, busy, done, converged, slp_t_en;
  logic [SW-1:0] ld_in = '0, slp_in;
  logic [OP-1:0] ld_train = '0, slp_train, slp_out = '0;
  logic [7:0] slp_rate;
  logic [2:0] epoch;
  logic [4:0] err_cnt;
  int checks = 0, failures = 0;
  logic [SW+OP-1:0] smp[$];
  bit wrong[MAXE][DEPTH];
  slp_train_ctrl #(.IN(IN), .I_PREC(IP), .O_PREC(OP), .R_PREC(8), .DEPTH(DEPTH), .MAX_EPOCH(MAXE),
    .RATE_INIT(8'h40), .RATE_SHIFT(1), .RATE_MIN(8'h01)) dut (
    .clk(clk), .reset_(reset_), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_in(ld_in),
    .ld_train(ld_train), .clr(clr), .start(start), .abort(abort), .busy(busy), .done(done),
    .converged(converged), .epoch(epoch), .err_cnt(err_cnt), .slp_in(slp_in),
    .slp_train(slp_train), .slp_rate(slp_rate), .slp_t_en(slp_t_en), .slp_out(slp_out));
  always #5 clk = ~clk;

  task automatic push(input logic [SW-1:0] d, input logic [OP-1:0] t);
    ld_valid = 1; ld_in = d; ld_train = t;
    checks++;
    if (ld_ready !== (smp.size() < DEPTH)) begin
      failures++; $display("FAIL ld_ready got=%b want=%b", ld_ready, smp.size() < DEPTH);
    end
    if (smp.size() < DEPTH) smp.push_back({d, t});
    @(negedge clk);
    ld_valid = 0;
  endtask

  task automatic load_rand(input int n);
    for (int i = 0; i < n; i++) push(SW'($urandom), OP'($urandom));
  endtask

  task automatic clear();
    clr = 1; @(negedge clk); clr = 0; smp.delete();
  endtask

  // conv_ep: first epoch with no mispredictions; abort_n: t_en index to abort at (-1 none)
  task automatic run(input int conv_ep, input int abort_n);
    int cnt, eps, last_e, tot, n, e_run, cyc, r;
    bit conv;
    int rate[MAXE];
    logic [SW+OP-1:0] s;
    cnt = smp.size();
    for (int ep = 0; ep < MAXE; ep++) begin
      bit any;
      any = 0;
      for (int k = 0; k < DEPTH; k++) begin
        wrong[ep][k] = (ep < conv_ep && k < cnt) ? bit'($urandom_range(0, 1)) : 1'b0;
        any |= wrong[ep][k];
      end
      if (ep < conv_ep && !any) wrong[ep][$urandom_range(0, cnt - 1)] = 1'b1;
    end
    eps = MAXE; conv = 0; last_e = 0; r = 64;
    for (int ep = 0; ep < MAXE; ep++) begin
      int e;
      e = 0;
      rate[ep] = r;
      r = (r / 2 < 1) ? 1 : r / 2;
      for (int k = 0; k < cnt; k++) e += int'(wrong[ep][k]);
      last_e = e;
      if (e == 0) begin conv = 1; eps = ep + 1; break; end
    end
    tot = eps * cnt;
    start = 1; @(negedge clk); start = 0;
    cyc = 1; n = 0; e_run = 0;
    forever begin
      if (slp_t_en) begin
        int k, ep;
        logic [OP-1:0] et;
        k = n % cnt; ep = n / cnt;
        s = smp[k % DEPTH];
        et = s[OP-1:0];
        if (k == 0) e_run = 0;
        checks++;
        if (n >= tot) begin
          failures++; $display("FAIL extra_t_en got=%0d want<%0d", n, tot);
        end else if (slp_in !== s[SW+OP-1:OP] || slp_train !== et || slp_rate !== 8'(rate[ep])
                     || epoch !== 3'(ep) || err_cnt !== 5'(e_run)) begin
          failures++;
          $display("FAIL replay n=%0d got in=%h tr=%h rate=%h ep=%0d err=%0d want in=%h tr=%h rate=%h ep=%0d err=%0d",
                   n, slp_in, slp_train, slp_rate, epoch, err_cnt, s[SW+OP-1:OP], et, rate[ep], ep, e_run);
        end
        slp_out = et ^ OP'(wrong[ep % MAXE][k % DEPTH]);
        e_run += int'(wrong[ep % MAXE][k % DEPTH]);
        if (n == abort_n) begin
          ld_valid = 0; clr = 0; start = 0;
          abort = 1; #1;
          checks++;
          if (slp_t_en !== 1'b0) begin failures++; $display("FAIL abort_t_en got=%b want=0", slp_t_en); end
          @(negedge clk); abort = 0;
          checks++;
          if ({busy, done, converged} !== 3'b000) begin
            failures++; $display("FAIL abort_idle got busy/done/conv=%b want=000", {busy, done, converged});
          end
          repeat (3) begin
            @(negedge clk);
            checks++;
            if ({done, slp_t_en, busy} !== 3'b000) begin
              failures++; $display("FAIL abort_quiet got done/t_en/busy=%b want=000", {done, slp_t_en, busy});
            end
          end
          return;
        end
        n++;
      end
      if (done) break;
      if (cyc > 1 + eps * (2 * cnt + 1) + 4) begin
        checks++; failures++; $display("FAIL timeout got cyc=%0d want done by %0d", cyc, 1 + eps * (2 * cnt + 1));
        break;
      end
      ld_valid = 1'($urandom); clr = 1'($urandom); start = 1'($urandom); ld_in = SW'($urandom);
      @(negedge clk); cyc++;
    end
    ld_valid = 0; clr = 0; start = 0;
    checks++;
    if (cyc !== 1 + eps * (2 * cnt + 1) || n !== tot) begin
      failures++; $display("FAIL run_len got cyc=%0d t_en=%0d want cyc=%0d t_en=%0d", cyc, n, 1 + eps * (2 * cnt + 1), tot);
    end
    checks++;
    if (converged !== conv || epoch !== 3'(eps - 1) || err_cnt !== 5'(last_e)) begin
      failures++; $display("FAIL result got conv=%b ep=%0d err=%0d want conv=%b ep=%0d err=%0d",
                           converged, epoch, err_cnt, conv, eps - 1, last_e);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, converged} !== {2'b00, conv}) begin
      failures++; $display("FAIL after_done got done/busy/conv=%b want 00%b", {done, busy, converged}, conv);
    end
  endtask

  task automatic test_reset();
    reset_ = 0; repeat (2) @(negedge clk); reset_ = 1;
    checks++;
    if ({busy, done, converged, slp_t_en, ld_ready} !== 5'b00001) begin
      failures++; $display("FAIL reset_flags got=%b want=00001", {busy, done, converged, slp_t_en, ld_ready});
    end
    checks++;
    if (slp_rate !== 8'h40 || epoch !== 3'd0 || err_cnt !== 5'd0 || slp_in !== '0 || slp_train !== '0) begin
      failures++; $display("FAIL reset_regs got rate=%h ep=%0d err=%0d in=%h tr=%h want 40/0/0/0/0",
                           slp_rate, epoch, err_cnt, slp_in, slp_train);
    end
  endtask

  task automatic test_and_gate();
    clear();
    for (int i = 0; i < 4; i++) push({8'(i >> 1), 8'(i & 1)}, 8'((i >> 1) & i & 1));
    run($urandom_range(1, 4), -1);
  endtask

  task automatic test_xor_rate();
    clear();
    for (int i = 0; i < 4; i++) push({8'(i >> 1), 8'(i & 1)}, 8'(((i >> 1) ^ i) & 1));
    run(MAXE + 1, -1);
  endtask

  task automatic test_empty_start();
    clear();
    start = 1; @(negedge clk); start = 0;
    checks++;
    if ({done, converged, slp_t_en} !== 3'b100) begin
      failures++; $display("FAIL empty_start got done/conv/t_en=%b want=100", {done, converged, slp_t_en});
    end
    @(negedge clk);
    checks++;
    if ({done, busy, slp_t_en} !== 3'b000) begin
      failures++; $display("FAIL empty_after got done/busy/t_en=%b want=000", {done, busy, slp_t_en});
    end
  endtask

  task automatic test_fill();
    clear();
    load_rand(DEPTH + 2);
    checks++;
    if (smp.size() !== DEPTH || ld_ready !== 1'b0) begin
      failures++; $display("FAIL fill got accepted=%0d ready=%b want %0d/0", smp.size(), ld_ready, DEPTH);
    end
    run($urandom_range(0, MAXE + 1), -1);
  endtask

  task automatic test_abort();
    clear();
    load_rand($urandom_range(2, 6));
    run(MAXE + 1, 2 * smp.size() + $urandom_range(0, smp.size() - 1));
    run($urandom_range(1, MAXE + 1), -1);
  endtask

  task automatic test_async_reset();
    clear();
    load_rand(3);
    start = 1; @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    #2 reset_ = 0; #1;
    checks++;
    if ({busy, slp_t_en, ld_ready} !== 3'b001) begin
      failures++; $display("FAIL async_reset got busy/t_en/ready=%b want=001", {busy, slp_t_en, ld_ready});
    end
    @(negedge clk); reset_ = 1; smp.delete();
    test_empty_start();
    load_rand(2);
    run(1, -1);
  endtask

  initial begin
    test_reset();
    test_and_gate();
    test_xor_rate();
    test_empty_start();
    test_fill();
    test_abort();
    for (int i = 0; i < 4; i++) begin
      clear();
      load_rand($urandom_range(1, DEPTH));
      run($urandom_range(0, MAXE + 1), -1);
    end
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
